cpu_led_pwm: RTL and testbench

//  Downstream stage of the CPU LED PIO: takes the PIO's registered LED pattern and drives the

---
 rtl/cpu_led_pwm.sv | 108 ++++++++++
 tb/tb_cpu_led_pwm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_led_pwm.sv
// Global-brightness PWM driver for the CPU LED PIO pattern, with frame-aligned shadowing.
// Optional blink gating is built when CPU_LED_PWM_BLINK_EN is defined.
module cpu_led_pwm #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [7:0]       brightness,
    input  logic             blink_en,
    output logic [WIDTH-1:0] led_out,
    output logic             frame_tick
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0]      prescaler;
    logic [7:0]       pwm_cnt;
    logic [WIDTH-1:0] act_pattern;
    logic [7:0]       act_bright;
    logic             tick;
    logic             boundary;
    logic             pwm_on;
    logic             blink_gate;

    assign tick     = (prescaler == PS_LAST);
    assign boundary = tick && (pwm_cnt == 8'hFF);
    assign pwm_on   = (act_bright == 8'hFF) || (pwm_cnt < act_bright);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // Shadow registers only follow the inputs at the frame boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt     <= '0;
            act_pattern <= '0;
            act_bright  <= '0;
        end else if (boundary) begin
            pwm_cnt     <= '0;
            act_pattern <= pattern_in;
            act_bright  <= brightness;
        end else if (tick) begin
            pwm_cnt     <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            led_out    <= act_pattern & {WIDTH{pwm_on && blink_gate}};
            frame_tick <= boundary;
        end
    end

`ifdef CPU_LED_PWM_BLINK_EN
    localparam logic [15:0] BF_LAST = 16'(BLINK_FRAMES - 1);

    logic        act_blink;
    logic [15:0] blink_cnt;
    logic        blink_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_blink <= 1'b0;
        end else if (boundary) begin
            act_blink <= blink_en;
        end
    end

    // Held at a fresh on-phase while blink is inactive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!act_blink) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (boundary) begin
            if (blink_cnt == BF_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 16'd1;
            end
        end
    end

    assign blink_gate = ~act_blink | blink_phase;
`else
    logic unused_blink_en;

    assign unused_blink_en = blink_en;
    assign blink_gate      = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_led_pwm.sv
// Scoreboard bench for cpu_led_pwm with PRESCALE=2, BLINK_FRAMES=2.
// Expected outputs are derived from the cycle index since reset (frame = 512 cycles).
module tb_cpu_led_pwm;

    localparam int FRAME = 512;
    localparam int BF    = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] pattern_in;
    logic [7:0] brightness;
    logic       blink_en;
    logic [7:0] led_out;
    logic       frame_tick;

    cpu_led_pwm #(
        .WIDTH(8),
        .PRESCALE(2),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pattern_in(pattern_in),
        .brightness(brightness),
        .blink_en(blink_en),
        .led_out(led_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] sb_q[$];

    int         n;
    logic [7:0] m_pat;
    logic [7:0] m_bri;
    logic       m_blk;
    int         m_bcnt;
    logic       m_phase;
    int         on_cnt;
    int         tick_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        n       = 0;
        m_pat   = '0;
        m_bri   = '0;
        m_blk   = 1'b0;
        m_bcnt  = 0;
        m_phase = 1'b1;
        sb_q.delete();
    endtask

    function automatic logic model_gate();
`ifdef CPU_LED_PWM_BLINK_EN
        return !m_blk || m_phase;
`else
        return 1'b1;
`endif
    endfunction

    // One clock: predict the output after the coming edge, then compare it.
    task automatic step();
        logic [8:0] e;
        logic [8:0] g;
        int         p;
        logic       on;
        p  = (n / 2) % 256;
        on = (m_bri == 8'hFF) || (p < int'(m_bri));
        e  = {((n + 1) % FRAME) == 0, m_pat & {8{on && model_gate()}}};
        sb_q.push_back(e);
        if (((n + 1) % FRAME) == 0) begin
            if (!m_blk) begin
                m_bcnt  = 0;
                m_phase = 1'b1;
            end else if (m_bcnt == BF - 1) begin
                m_bcnt  = 0;
                m_phase = ~m_phase;
            end else begin
                m_bcnt++;
            end
            m_pat = pattern_in;
            m_bri = brightness;
            m_blk = blink_en;
        end
        @(posedge clk);
        n++;
        #1;
        g = sb_q.pop_front();
        check_eq("led_out", 32'(led_out), 32'(g[7:0]));
        check_eq("frame_tick", 32'(frame_tick), 32'(g[8]));
        if (led_out != 8'h00) on_cnt++;
        if (frame_tick) tick_cnt++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic run_to_boundary();
        do step(); while ((n % FRAME) != 0);
    endtask

    task automatic frame_count(input string tag, input int exp_on);
        on_cnt   = 0;
        tick_cnt = 0;
        run(FRAME);
        check_eq(tag, 32'(on_cnt), 32'(exp_on));
        check_eq("ticks_per_frame", 32'(tick_cnt), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        pattern_in = 8'hA5;
        brightness = 8'hFF;
        blink_en   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_led", 32'(led_out), 32'd0);
        check_eq("reset_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full brightness: dark until first frame start, then constant.
        on_cnt = 0;
        run(FRAME);
        check_eq("pre_first_frame_on", 32'(on_cnt), 32'd0);
        frame_count("a5_full_on", FRAME);

        // Quarter duty: 64 ticks = 128 cycles on per frame.
        pattern_in = 8'hFF;
        brightness = 8'h40;
        run_to_boundary();
        frame_count("duty40_frame0", 128);
        frame_count("duty40_frame1", 128);

        // Mid-frame brightness write waits for the next frame.
        on_cnt   = 0;
        tick_cnt = 0;
        run(100);
        brightness = 8'hC0;
        run(FRAME - 100);
        check_eq("midframe_write_old", 32'(on_cnt), 32'd128);
        frame_count("midframe_write_new", 384);

        // Zero brightness keeps LEDs dark but frames keep ticking.
        brightness = 8'h00;
        run_to_boundary();
        for (int f = 0; f < 3; f++) frame_count("bright0_dark", 0);

        // Asynchronous reset mid-frame.
        brightness = 8'hFF;
        run_to_boundary();
        run(50);
        check_eq("pre_reset_led", 32'(led_out), 32'hFF);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_led", 32'(led_out), 32'd0);
        check_eq("async_reset_tick", 32'(frame_tick), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        on_cnt = 0;
        run(FRAME);
        check_eq("post_reset_dark", 32'(on_cnt), 32'd0);
        frame_count("post_reset_resume", FRAME);

        // Blink: two frames on, two frames off when built in.
        pattern_in = 8'h0F;
        blink_en   = 1'b1;
        run_to_boundary();
        for (int f = 0; f < 8; f++) begin
`ifdef CPU_LED_PWM_BLINK_EN
            frame_count("blink_frame", ((f % 4) < 2) ? FRAME : 0);
`else
            frame_count("blink_frame", FRAME);
`endif
        end
        check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
